pollable_memory_arbiter: RTL

- Shares one simple-dual-port RAM (7-bit address, 7-bit data, registered read) between two requesters.
- Requester "host" is the parallel-bus slave: host-initiated address/data writes and polled reads.
- Requester "seq" is an internal playback sequencer that streams RAM contents to the oserdes function generator.
- The block arbitrates per cycle, drives the RAM ports, and returns tagged read data to the originating requester.

---
 rtl/pollable_memory_arbiter_pkg.sv | 15 +
 rtl/pollable_memory_arbiter_read_return_pipe.sv | 44 ++++
 rtl/pollable_memory_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/pollable_memory_arbiter_pkg.sv
// Shared widths, defaults and read-owner tag encoding for the memory arbiter.
package pollable_memory_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 7;
  localparam int unsigned DATA_WIDTH_DEF = 7;
  localparam int unsigned MAX_WAIT_DEF   = 4;

  // Identifies which requester a RAM read belongs to.
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_HOST = 2'd1,
    OWNER_SEQ  = 2'd2
  } owner_t;

endpackage

// File: rtl/pollable_memory_arbiter_read_return_pipe.sv
// Carries the read owner tag alongside the RAM read latency and steers the
// returned RAM data into the owning requester's rdata/valid outputs.
module pollable_memory_arbiter_read_return_pipe
  import pollable_memory_arbiter_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  owner_t                issue_owner,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_valid,
  output logic [DATA_WIDTH-1:0] seq_rdata,
  output logic                  seq_valid
);

  // tag[k] is the owner of the read whose address was on the RAM k cycles ago.
  owner_t tag [READ_LATENCY+1];

  // Shift the owner tag and capture ram_dout when the tagged read lands.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i <= READ_LATENCY; i++) begin
        tag[i] <= OWNER_NONE;
      end
      host_rdata <= '0;
      host_valid <= 1'b0;
      seq_rdata  <= '0;
      seq_valid  <= 1'b0;
    end else begin
      tag[0] <= issue_owner;
      for (int unsigned i = 1; i <= READ_LATENCY; i++) begin
        tag[i] <= tag[i-1];
      end
      host_valid <= (tag[READ_LATENCY] == OWNER_HOST);
      seq_valid  <= (tag[READ_LATENCY] == OWNER_SEQ);
      if (tag[READ_LATENCY] == OWNER_HOST) host_rdata <= ram_dout;
      if (tag[READ_LATENCY] == OWNER_SEQ)  seq_rdata  <= ram_dout;
    end
  end

endmodule

// File: rtl/pollable_memory_arbiter.sv
// Per-cycle arbiter sharing one simple-dual-port RAM between the host bus
// slave and the playback sequencer, with a starvation guard for the host.
module pollable_memory_arbiter
  import pollable_memory_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned MAX_WAIT     = MAX_WAIT_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  host_req,
  input  logic                  host_write,
  input  logic [ADDR_WIDTH-1:0] host_address,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_ack,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  host_valid,
  input  logic                  seq_req,
  input  logic [ADDR_WIDTH-1:0] seq_address,
  output logic                  seq_ack,
  output logic [DATA_WIDTH-1:0] seq_rdata,
  output logic                  seq_valid,
  output logic                  seq_late,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_din,
  output logic                  ram_write_en,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  logic [3:0] wait_count;
  logic       host_eligible;
  logic       seq_eligible;
  logic       seq_late_next;
  owner_t     grant;
  owner_t     read_owner;

  // Arbitration decision; a requester being acked this cycle is masked so a
  // held level request is not granted twice.
  always_comb begin
    host_eligible = host_req && !host_ack;
    seq_eligible  = seq_req && !seq_ack;
    grant         = OWNER_NONE;
    if (seq_eligible && host_eligible) begin
      grant = (wait_count == WAIT_LIMIT) ? OWNER_HOST : OWNER_SEQ;
    end else if (seq_eligible) begin
      grant = OWNER_SEQ;
    end else if (host_eligible) begin
      grant = OWNER_HOST;
    end
    seq_late_next = seq_eligible && (grant == OWNER_HOST);
    read_owner    = OWNER_NONE;
    if (grant == OWNER_SEQ) begin
      read_owner = OWNER_SEQ;
    end else if (grant == OWNER_HOST && !host_write) begin
      read_owner = OWNER_HOST;
    end
  end

  // Register the grant into acks, RAM port drive and the host wait counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      host_ack     <= 1'b0;
      seq_ack      <= 1'b0;
      seq_late     <= 1'b0;
      ram_write_en <= 1'b0;
      ram_waddr    <= '0;
      ram_din      <= '0;
      ram_raddr    <= '0;
      wait_count   <= '0;
    end else begin
      host_ack     <= (grant == OWNER_HOST);
      seq_ack      <= (grant == OWNER_SEQ);
      seq_late     <= seq_late_next;
      ram_write_en <= (grant == OWNER_HOST) && host_write;
      if (grant == OWNER_HOST && host_write) begin
        ram_waddr <= host_address;
        ram_din   <= host_wdata;
      end
      if (read_owner == OWNER_HOST) begin
        ram_raddr <= host_address;
      end else if (read_owner == OWNER_SEQ) begin
        ram_raddr <= seq_address;
      end
      if (grant == OWNER_HOST) begin
        wait_count <= '0;
      end else if (host_eligible && wait_count < WAIT_LIMIT) begin
        wait_count <= wait_count + 4'd1;
      end
    end
  end

  pollable_memory_arbiter_read_return_pipe #(
    .READ_LATENCY (READ_LATENCY),
    .DATA_WIDTH   (DATA_WIDTH)
  ) u_read_return_pipe (
    .clock       (clock),
    .reset       (reset),
    .issue_owner (read_owner),
    .ram_dout    (ram_dout),
    .host_rdata  (host_rdata),
    .host_valid  (host_valid),
    .seq_rdata   (seq_rdata),
    .seq_valid   (seq_valid)
  );

endmodule
